// File: rtl/i2c_pkg.sv
// i2c_pkg
// Definitions shared by the I2C target and the I2C master:
//   - the 7-bit bus address width
//   - the target FSM state encoding
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        MACK,
        IGNORE
    } i2c_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync
// Brings the asynchronous SCL/SDA levels into the clk domain and derives
// edge strobes plus the START/STOP bus conditions.
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   scl_in, sda_in      raw bus levels
//   sda_s               synchronized SDA level
//   scl_rise, scl_fall  one-cycle SCL edge strobes
//   start_det           SDA fell while SCL was steadily high
//   stop_det            SDA rose while SCL was steadily high
module i2c_bus_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   scl_d;
    logic                   sda_d;

    // Everything resets to the idle-bus level (high) so that leaving
    // reset on a quiet bus produces no edge strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;

    // SCL must be high in both the current and previous sample so that an
    // SDA change racing an SCL edge is not mistaken for a bus condition.
    assign start_det = sda_d & ~sda_s & scl_s & scl_d;
    assign stop_det  = ~sda_d & sda_s & scl_s & scl_d;

endmodule

// File: rtl/i2c_slave.sv
// i2c_slave
// I2C target: answers to SLAVE_ADDR, hands written bytes to local logic
// and fetches read bytes from it. SCL is sampled as data, never used as a
// clock, and is never stretched.
// Ports:
//   clk, reset     system clock (>= 8x SCL), asynchronous active-high reset
//   scl_in, sda_in raw bus levels
//   sda_oe         1 = pull SDA low
//   wr_valid       pulse, wr_data holds a freshly received write byte
//   wr_data        last received write byte
//   rd_req         pulse, local logic presents the next read byte
//   rd_data        read byte, sampled 2 clk after rd_req
//   addressed      high from our address ACK until STOP / repeated START
//   start_seen     pulse on every START or repeated START
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h42,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [7:0] wr_data,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    output logic       addressed,
    output logic       start_seen
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_t state, state_n;
    logic [3:0] bit_cnt, cnt_n;
    logic [1:0] load_cnt, load_n;
    logic [7:0] shreg, shreg_n;
    logic [7:0] wr_data_n;
    logic       rw, rw_n;
    logic       oe_n, wr_valid_n, rd_req_n, addressed_n, start_seen_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            load_cnt   <= '0;
            rw         <= 1'b0;
            sda_oe     <= 1'b0;
            wr_valid   <= 1'b0;
            wr_data    <= '0;
            rd_req     <= 1'b0;
            addressed  <= 1'b0;
            start_seen <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= cnt_n;
            load_cnt   <= load_n;
            rw         <= rw_n;
            sda_oe     <= oe_n;
            wr_valid   <= wr_valid_n;
            wr_data    <= wr_data_n;
            rd_req     <= rd_req_n;
            addressed  <= addressed_n;
            start_seen <= start_seen_n;
        end
    end

    // Shift register carries data only; its content is meaningless until
    // eight bits have been shifted or a read byte has been loaded.
    always_ff @(posedge clk) begin
        shreg <= shreg_n;
    end

    always_comb begin
        state_n      = state;
        cnt_n        = bit_cnt;
        load_n       = load_cnt;
        shreg_n      = shreg;
        rw_n         = rw;
        oe_n         = sda_oe;
        wr_data_n    = wr_data;
        addressed_n  = addressed;
        wr_valid_n   = 1'b0;
        rd_req_n     = 1'b0;
        start_seen_n = 1'b0;

        // Read byte arrives two clocks after rd_req. On the first byte of a
        // read the MSB goes on the bus as soon as it is loaded (SCL is
        // still low); after a master ACK it waits for the next scl_fall.
        if (load_cnt != 2'd0) begin
            load_n = load_cnt - 2'd1;
            if (load_cnt == 2'd1) begin
                shreg_n = rd_data;
                if (state == READ) oe_n = ~rd_data[7];
            end
        end

        if (start_det) begin
            state_n      = ADDR;
            cnt_n        = '0;
            load_n       = '0;
            oe_n         = 1'b0;
            addressed_n  = 1'b0;
            start_seen_n = 1'b1;
        end else if (stop_det) begin
            state_n     = IDLE;
            cnt_n       = '0;
            load_n      = '0;
            oe_n        = 1'b0;
            addressed_n = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shreg_n = {shreg[6:0], sda_s};
                        cnt_n   = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            // shreg[6:0] holds the seven address bits here
                            rw_n = sda_s;
                            if (shreg[6:0] != SLAVE_ADDR) state_n = IGNORE;
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        oe_n    = 1'b1;
                        state_n = ADDR_ACK;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        oe_n        = 1'b0;
                        cnt_n       = '0;
                        addressed_n = 1'b1;
                        if (rw) begin
                            state_n  = READ;
                            rd_req_n = 1'b1;
                            load_n   = 2'd2;
                        end else begin
                            state_n = WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shreg_n = {shreg[6:0], sda_s};
                        cnt_n   = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            wr_data_n  = {shreg[6:0], sda_s};
                            wr_valid_n = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        oe_n    = 1'b1;
                        state_n = WRITE_ACK;
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall) begin
                        oe_n    = 1'b0;
                        cnt_n   = '0;
                        state_n = WRITE;
                    end
                end
                READ: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd7) begin
                            oe_n    = 1'b0;
                            cnt_n   = '0;
                            state_n = MACK;
                        end else begin
                            shreg_n = {shreg[6:0], 1'b0};
                            oe_n    = ~shreg[6];
                            cnt_n   = bit_cnt + 4'd1;
                        end
                    end
                end
                MACK: begin
                    // bit_cnt == 8 marks "master ACKed, next byte requested"
                    if (scl_rise && bit_cnt == 4'd0) begin
                        if (!sda_s) begin
                            rd_req_n = 1'b1;
                            load_n   = 2'd2;
                            cnt_n    = 4'd8;
                        end else begin
                            state_n = IGNORE;
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        oe_n    = ~shreg[7];
                        cnt_n   = '0;
                        state_n = READ;
                    end
                end
                default: begin
                    oe_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave
// Directed bench: a behavioural bus master drives SCL/SDA (open-drain
// wired-AND with the target's sda_oe) and a local-logic model answers
// rd_req from a small byte table.
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam int Q = 5;   // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_oe, wr_valid, rd_req, addressed, start_seen;
    logic [7:0] wr_data;
    logic [7:0] rd_data = 8'h00;
    wire        sda_bus = sda_m & ~sda_oe;

    i2c_slave #(.SLAVE_ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .scl_in     (scl_m),
        .sda_in     (sda_bus),
        .sda_oe     (sda_oe),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .addressed  (addressed),
        .start_seen (start_seen)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_bad = 0;
    int         n_wr, n_rd, n_st, rd_idx;
    logic       oe_seen;
    logic       mon_clr = 1'b1;
    logic [7:0] wr_log [4];
    logic [7:0] rd_tab [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulse counters and local read-data source, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_clr) begin
                n_wr = 0; n_rd = 0; n_st = 0; rd_idx = 0; oe_seen = 1'b0;
            end else begin
                if (wr_valid) begin
                    if (n_wr < 4) wr_log[n_wr] = wr_data;
                    n_wr++;
                end
                if (rd_req) begin
                    rd_data = rd_tab[rd_idx % 4];
                    rd_idx++;
                    n_rd++;
                end
                if (start_seen) n_st++;
                if (sda_oe) oe_seen = 1'b1;
            end
        end
    end

    task automatic wq(input int n = Q);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
    endtask

    task automatic clk_bit(input logic b, output logic s);
        sda_m = b;  wq();
        scl_m = 1'b1; wq();
        s = sda_bus; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq();
        wq();
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack_n);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, ack_n);
    endtask

    task automatic rd_byte(output logic [7:0] d, input logic nack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(nack, s);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;

        // reset state
        wq(4);
        chk("rst_oe", sda_oe, 0);
        chk("rst_wrv", wr_valid, 0);
        chk("rst_rdreq", rd_req, 0);
        chk("rst_addr", addressed, 0);
        chk("rst_start", start_seen, 0);
        chk("rst_wrdata", wr_data, 0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        reset = 1'b0;
        wq(4);
        clr_mon();
        chk("rel_no_pulse", n_st + n_wr + n_rd, 0);

        // write 0xA5, 0x3C to 0x42
        clr_mon();
        bus_start();
        wr_byte(8'h84, ack);  chk("w_addr_ack", ack, 0);
        chk("w_addressed", addressed, 1);
        wr_byte(8'hA5, ack);  chk("w_b0_ack", ack, 0);
        wr_byte(8'h3C, ack);  chk("w_b1_ack", ack, 0);
        bus_stop();
        chk("w_nwr", n_wr, 2);
        chk("w_log0", wr_log[0], 8'hA5);
        chk("w_log1", wr_log[1], 8'h3C);
        chk("w_wrdata", wr_data, 8'h3C);
        chk("w_addr_stop", addressed, 0);
        chk("w_nstart", n_st, 1);

        // wrong address 0x43
        clr_mon();
        bus_start();
        wr_byte(8'h86, ack);  chk("na_addr_ack", ack, 1);
        wr_byte(8'h55, ack);  chk("na_b0_ack", ack, 1);
        chk("na_state", 32'(dut.state), 32'(IGNORE));
        bus_stop();
        chk("na_oe_seen", oe_seen, 0);
        chk("na_nwr", n_wr, 0);
        chk("na_state_stop", 32'(dut.state), 32'(IDLE));

        // read 0x96 (ACK), 0x0F (NACK)
        rd_tab[0] = 8'h96; rd_tab[1] = 8'h0F;
        clr_mon();
        bus_start();
        wr_byte(8'h85, ack);  chk("r_addr_ack", ack, 0);
        rd_byte(d, 1'b0);     chk("r_b0", d, 8'h96);
        rd_byte(d, 1'b1);     chk("r_b1", d, 8'h0F);
        chk("r_oe_after_nack", sda_oe, 0);
        chk("r_state_nack", 32'(dut.state), 32'(IGNORE));
        bus_stop();
        chk("r_nrd", n_rd, 2);

        // write 0x01, partial byte, repeated START, read
        rd_tab[0] = 8'h77;
        clr_mon();
        bus_start();
        wr_byte(8'h84, ack);  chk("rs_addr_ack", ack, 0);
        wr_byte(8'h01, ack);  chk("rs_b0_ack", ack, 0);
        clk_bit(1'b1, s); clk_bit(1'b0, s); clk_bit(1'b1, s);
        bus_start();
        chk("rs_addr_clr", addressed, 0);
        wr_byte(8'h85, ack);  chk("rs_raddr_ack", ack, 0);
        rd_byte(d, 1'b1);     chk("rs_rd", d, 8'h77);
        bus_stop();
        chk("rs_nstart", n_st, 2);
        chk("rs_nwr", n_wr, 1);
        chk("rs_log0", wr_log[0], 8'h01);
        chk("rs_nrd", n_rd, 1);

        // reset during bit 4 of a read byte driven low
        rd_tab[0] = 8'h00;
        clr_mon();
        bus_start();
        wr_byte(8'h85, ack);  chk("mr_addr_ack", ack, 0);
        clk_bit(1'b1, s); clk_bit(1'b1, s); clk_bit(1'b1, s);
        chk("mr_oe_bit4", sda_oe, 1);
        reset = 1'b1;
        #1;
        chk("mr_oe_async", sda_oe, 0);
        chk("mr_state", 32'(dut.state), 32'(IDLE));
        wq(3);
        reset = 1'b0;
        wq(2);
        clr_mon();
        wr_byte(8'h84, ack);  chk("mr_ignored_ack", ack, 1);
        bus_stop();
        chk("mr_oe_seen", oe_seen, 0);
        chk("mr_nwr", n_wr, 0);
        chk("mr_nst", n_st, 0);
        bus_start();
        wr_byte(8'h84, ack);  chk("mr_next_ack", ack, 0);
        bus_stop();

        // START then STOP only SYNC_STAGES+2 clk apart
        wq(4);
        clr_mon();
        sda_m = 1'b0; wq(4);
        sda_m = 1'b1; wq(10);
        chk("fs_nst", n_st, 1);
        chk("fs_state", 32'(dut.state), 32'(IDLE));
        chk("fs_cnt", dut.bit_cnt, 0);
        chk("fs_oe_seen", oe_seen, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
